vsoc_mem_arbiter: RTL and testbench

- Round-robin arbiter that shares the single-port data SRAM between `N_REQ` requesters, e.g. scalar load/store unit, vector load/store unit and boot/DMA loader.
- Supports burst locking, so a vector unit can stream consecutive beats without interleaving.
- Routes 1-cycle-latency read data back to the requester that issued the read.
- Sits between the execution units and the memory macro inside `VectorSOC`.

---
 rtl/vsoc_mem_pkg.sv | 14 +
 rtl/vsoc_rr_picker.sv | 30 +++
 rtl/vsoc_mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_vsoc_mem_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vsoc_mem_pkg.sv
// Shared types and constants for the VectorSOC data-memory path.
// Imported by the arbiter and its round-robin picker.
package vsoc_mem_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int MEM_RD_LATENCY = 1;
    localparam int DEF_ADDR_W     = 16;
    localparam int DEF_DATA_W     = 32;

endpackage

// File: rtl/vsoc_rr_picker.sv
// Combinational round-robin pick: first valid bit after last_grant,
// wrapping modulo N.
module vsoc_rr_picker #(
    parameter int N    = 3,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    valid,
    input  logic [ID_W-1:0] last_grant,
    output logic [N-1:0]    gnt_onehot,
    output logic [ID_W-1:0] gnt_id,
    output logic            any
);

    always_comb begin
        int idx;
        gnt_onehot = '0;
        gnt_id     = '0;
        any        = 1'b0;
        idx        = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last_grant) + k) % N;
            if (!any && valid[idx]) begin
                any             = 1'b1;
                gnt_id          = ID_W'(idx);
                gnt_onehot[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vsoc_mem_arbiter.sv
// Round-robin, burst-locking arbiter for the shared single-port data SRAM.
// Read data returns one cycle later, tagged to the issuing requester.
module vsoc_mem_arbiter
    import vsoc_mem_pkg::*;
#(
    parameter int N_REQ     = 3,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_BURST = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ-1:0]           req_we,
    input  logic [N_REQ-1:0]           req_last,
    input  logic [N_REQ*ADDR_W-1:0]    req_addr,
    input  logic [N_REQ*DATA_W-1:0]    req_wdata,
    input  logic [N_REQ*DATA_W/8-1:0]  req_wstrb,
    output logic [N_REQ-1:0]           rsp_valid,
    output logic [DATA_W-1:0]          rsp_rdata,
    output logic                       mem_en,
    output logic                       mem_we,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    output logic [DATA_W/8-1:0]        mem_wstrb,
    input  logic [DATA_W-1:0]          mem_rdata,
    output logic                       busy,
    output logic [$clog2(N_REQ)-1:0]   grant_id
);

    localparam int ID_W   = $clog2(N_REQ);
    localparam int STRB_W = DATA_W / 8;
    localparam bit CAN_LOCK = (MAX_BURST > 1);
    localparam logic [7:0] LAST_CNT = 8'(MAX_BURST - 1);

    arb_state_t      state;
    logic [ID_W-1:0] owner;
    logic [ID_W-1:0] last_grant;
    logic [ID_W-1:0] rd_id;
    logic [7:0]      beat_cnt;
    logic            rd_pending;

    logic [N_REQ-1:0] pick_oh;
    logic [ID_W-1:0]  pick_id;
    logic             pick_any;

    logic [N_REQ-1:0] ready;
    logic [ID_W-1:0]  sel;
    logic             accept;
    logic             sel_we;
    logic             sel_last;

    vsoc_rr_picker #(
        .N    (N_REQ),
        .ID_W (ID_W)
    ) u_picker (
        .valid      (req_valid),
        .last_grant (last_grant),
        .gnt_onehot (pick_oh),
        .gnt_id     (pick_id),
        .any        (pick_any)
    );

    // In LOCKED only the owner can be granted; others are masked out.
    always_comb begin
        ready = '0;
        sel   = pick_id;
        if (!reset) begin
            if (state == IDLE) begin
                if (pick_any) ready = pick_oh;
            end else begin
                sel          = owner;
                ready[owner] = req_valid[owner];
            end
        end
    end

    assign req_ready = ready;
    assign accept    = |ready;
    assign sel_we    = req_we[sel];
    assign sel_last  = req_last[sel];

    always_comb begin
        mem_en    = accept;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        if (accept) begin
            mem_we    = sel_we;
            mem_addr  = req_addr[int'(sel)*ADDR_W +: ADDR_W];
            mem_wdata = req_wdata[int'(sel)*DATA_W +: DATA_W];
            mem_wstrb = req_wstrb[int'(sel)*STRB_W +: STRB_W];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= '0;
            last_grant <= ID_W'(N_REQ - 1);
            beat_cnt   <= '0;
            grant_id   <= '0;
            rd_pending <= 1'b0;
            rd_id      <= '0;
        end else begin
            rd_pending <= accept & ~sel_we;
            if (accept) rd_id <= sel;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        grant_id <= sel;
                        if (!sel_last && CAN_LOCK) begin
                            state    <= LOCKED;
                            owner    <= sel;
                            beat_cnt <= 8'd1;
                        end else begin
                            last_grant <= sel;
                        end
                    end
                end
                LOCKED: begin
                    if (!req_valid[owner]) begin
                        state      <= IDLE;
                        last_grant <= owner;
                        beat_cnt   <= '0;
                    end else begin
                        grant_id <= owner;
                        if (sel_last || beat_cnt == LAST_CNT) begin
                            state      <= IDLE;
                            last_grant <= owner;
                            beat_cnt   <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + 8'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A read still in flight when reset rises is dropped.
    always_comb begin
        rsp_valid = '0;
        if (rd_pending && !reset) rsp_valid[rd_id] = 1'b1;
    end

    assign rsp_rdata = rd_pending ? mem_rdata : '0;
    assign busy      = (state == LOCKED);

endmodule

// File: tb/tb_vsoc_mem_arbiter.sv
// Randomized bench for vsoc_mem_arbiter: per-cycle grant model plus a
// read-response scoreboard drained by an independent monitor.
module tb_vsoc_mem_arbiter;

    localparam int N    = 3;
    localparam int AW   = 16;
    localparam int DW   = 32;
    localparam int SW   = DW / 8;
    localparam int MB   = 8;
    localparam int IW   = $clog2(N);
    localparam int NCYC = 3000;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      req_we = '0;
    logic [N-1:0]      req_last = '0;
    logic [N*AW-1:0]   req_addr = '0;
    logic [N*DW-1:0]   req_wdata = '0;
    logic [N*SW-1:0]   req_wstrb = '0;
    logic [N-1:0]      rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [SW-1:0]     mem_wstrb;
    logic [DW-1:0]     mem_rdata;
    logic              busy;
    logic [IW-1:0]     grant_id;

    vsoc_mem_arbiter #(
        .N_REQ     (N),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .MAX_BURST (MB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_last  (req_last),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] ram    [32];
    logic [DW-1:0] shadow [32];

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < SW; b++)
                    if (mem_wstrb[b]) ram[mem_addr[4:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end else begin
                mem_rdata <= ram[mem_addr[4:0]];
            end
        end
    end

    typedef struct {
        int            id;
        logic [DW-1:0] data;
        int            due;
    } rsp_t;

    rsp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    always begin
        @(negedge clk);
        #2;
        if (rsp_valid !== '0) begin
            if (q.size() == 0) begin
                chk("rsp_unexpected", 64'(rsp_valid), 64'(0));
            end else begin
                rsp_t e;
                logic [N-1:0] oh;
                e = q.pop_front();
                oh = '0;
                oh[e.id] = 1'b1;
                chk("rsp_valid", 64'(rsp_valid), 64'(oh));
                chk("rsp_rdata", 64'(rsp_rdata), 64'(e.data));
                chk("rsp_latency", 64'(cyc), 64'(e.due));
            end
        end else if (q.size() != 0 && q[0].due <= cyc) begin
            logic [N-1:0] oh;
            oh = '0;
            oh[q[0].id] = 1'b1;
            chk("rsp_missing", 64'(rsp_valid), 64'(oh));
            void'(q.pop_front());
        end
    end

    bit m_locked = 1'b0;
    int m_owner = 0;
    int m_lg = N - 1;
    int m_cnt = 0;
    int m_gid = 0;

    bit hold [N];
    int left [N];

    initial begin
        int rst_left;
        bit quiet;
        int w;
        int j;
        logic [N-1:0]  er;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [SW-1:0] s;
        rsp_t e;

        for (int i = 0; i < 32; i++) begin
            ram[i] = 32'h1357_0000 + 32'(i * 32'h0101);
            shadow[i] = ram[i];
        end
        ram[16] = 32'hDEAD_BEEF;
        shadow[16] = 32'hDEAD_BEEF;
        for (int i = 0; i < N; i++) begin
            hold[i] = 1'b0;
            left[i] = 0;
        end
        rst_left = 3;

        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            if (rst_left > 0) begin
                reset = 1'b1;
                rst_left--;
            end else begin
                reset = 1'b0;
                if (c > 50 && $urandom_range(0, 249) == 0) rst_left = 2;
            end
            if (reset) q.delete();
            quiet = (c >= NCYC - 5);

            for (int i = 0; i < N; i++) begin
                if (!hold[i] && !quiet) begin
                    if (left[i] == 0 && $urandom_range(0, 3) != 0)
                        left[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, 12)) : 1;
                    if (left[i] > 0) begin
                        hold[i] = 1'b1;
                        req_we[i] = 1'($urandom_range(0, 1));
                        req_addr[i*AW +: AW] = AW'($urandom_range(0, 31));
                        req_wdata[i*DW +: DW] = $urandom;
                        req_wstrb[i*SW +: SW] = SW'($urandom);
                        req_last[i] = (left[i] == 1);
                    end
                end
                req_valid[i] = hold[i] && !quiet && ($urandom_range(0, 11) != 0);
            end

            #1;
            w = -1;
            if (!reset) begin
                if (m_locked) begin
                    if (req_valid[m_owner]) w = m_owner;
                end else begin
                    for (int k = 1; k <= N; k++) begin
                        j = (m_lg + k) % N;
                        if (w < 0 && req_valid[j]) w = j;
                    end
                end
            end
            er = '0;
            if (w >= 0) er[w] = 1'b1;

            chk("req_ready", 64'(req_ready), 64'(er));
            chk("mem_en", 64'(mem_en), 64'(w >= 0));
            chk("busy", 64'(busy), 64'(m_locked));
            chk("grant_id", 64'(grant_id), 64'(m_gid));

            if (w >= 0) begin
                a = req_addr[w*AW +: AW];
                d = req_wdata[w*DW +: DW];
                s = req_wstrb[w*SW +: SW];
                chk("mem_we", 64'(mem_we), 64'(req_we[w]));
                chk("mem_addr", 64'(mem_addr), 64'(a));
                chk("mem_wdata", 64'(mem_wdata), 64'(d));
                chk("mem_wstrb", 64'(mem_wstrb), 64'(s));
                if (req_we[w]) begin
                    for (int b = 0; b < SW; b++)
                        if (s[b]) shadow[a[4:0]][b*8 +: 8] = d[b*8 +: 8];
                end else begin
                    e.id = w;
                    e.data = shadow[a[4:0]];
                    e.due = cyc + 1;
                    q.push_back(e);
                end
                hold[w] = 1'b0;
                left[w] = left[w] - 1;
            end else begin
                chk("mem_addr_idle", 64'(mem_addr), 64'(0));
                chk("mem_wdata_idle", 64'(mem_wdata), 64'(0));
            end

            if (reset) begin
                m_locked = 1'b0;
                m_owner = 0;
                m_lg = N - 1;
                m_cnt = 0;
                m_gid = 0;
            end else if (m_locked) begin
                if (w < 0) begin
                    m_locked = 1'b0;
                    m_lg = m_owner;
                end else begin
                    m_cnt++;
                    m_gid = m_owner;
                    if (req_last[m_owner] || m_cnt == MB) begin
                        m_locked = 1'b0;
                        m_lg = m_owner;
                    end
                end
            end else if (w >= 0) begin
                m_gid = w;
                if (!req_last[w] && MB > 1) begin
                    m_locked = 1'b1;
                    m_owner = w;
                    m_cnt = 1;
                end else begin
                    m_lg = w;
                end
            end
        end

        @(negedge clk);
        #3;
        if (q.size() != 0) chk("rsp_drain", 64'(q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
